tx_sync_fifo: RTL and testbench

Parametrised single-clock transmit FIFO, the next generation of the team's TX buffering path. It is used where the producer and the serialiser share one clock domain.
- Generalised in width and depth.
- Adds run-time programmable almost-full/almost-empty thresholds, a registered fill level, sticky overflow/underflow error flags and a registered read-valid strobe.
- Sits between the packet builder (push side) and the TX serialiser (pop side).

---
 rtl/tx_fifo_pkg.sv | 18 +
 rtl/tx_fifo_ram.sv | 24 ++
 rtl/tx_sync_fifo.sv | 162 ++++++++++++++++
 tb/tb_tx_sync_fifo.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_fifo_pkg.sv
// rtl/tx_fifo_pkg.sv - shared helpers for the TX sync FIFO
package tx_fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/tx_fifo_ram.sv
// rtl/tx_fifo_ram.sv - simple dual-port RAM, synchronous write, asynchronous read
module tx_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tx_sync_fifo.sv
// rtl/tx_sync_fifo.sv - single-clock TX FIFO with thresholds and sticky errors
// Optional first-word-fall-through read port: define TX_SYNC_FIFO_FWFT_EN.
module tx_sync_fifo
    import tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDR_WIDTH       = 4,
    parameter int RESET_AFULL_THR  = (1 << ADDR_WIDTH) - 2,
    parameter int RESET_AEMPTY_THR = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rvalid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_level,
    input  logic                  i_thr_load,
    input  logic [ADDR_WIDTH:0]   i_afull_thr,
    input  logic [ADDR_WIDTH:0]   i_aempty_thr,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic                  o_overflow,
    output logic                  o_underflow,
    input  logic                  i_clr_err
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PTR_W-1:0] L_DEPTH = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] L_RST_AFULL =
        (RESET_AFULL_THR > DEPTH) ? L_DEPTH : PTR_W'(RESET_AFULL_THR);
    localparam logic [PTR_W-1:0] L_RST_AEMPTY =
        (RESET_AEMPTY_THR > DEPTH) ? L_DEPTH : PTR_W'(RESET_AEMPTY_THR);

    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [PTR_W-1:0]      r_level;
    logic [PTR_W-1:0]      r_afull_thr;
    logic [PTR_W-1:0]      r_aempty_thr;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_ptr_full;
    logic                  w_ptr_empty;
    logic                  w_push_acc;
    logic                  w_pop_acc;
    logic [PTR_W-1:0]      w_level_next;
    logic [PTR_W-1:0]      w_afull_sat;
    logic [PTR_W-1:0]      w_aempty_sat;
    logic [PTR_W-1:0]      w_afull_eff;
    logic [PTR_W-1:0]      w_aempty_eff;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    assign w_ptr_empty = (r_wptr == r_rptr);
    assign w_ptr_full  = (r_wptr[PTR_W-1] != r_rptr[PTR_W-1]) &&
                         (r_wptr[PTR_W-2:0] == r_rptr[PTR_W-2:0]);

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
    assign w_pop_acc  = i_pop & ~w_ptr_empty;
    assign w_push_acc = i_push & (~w_ptr_full | w_pop_acc);

    assign w_level_next = r_level + {{(PTR_W-1){1'b0}}, w_push_acc}
                                  - {{(PTR_W-1){1'b0}}, w_pop_acc};

    assign w_afull_sat  = (i_afull_thr  > L_DEPTH) ? L_DEPTH : i_afull_thr;
    assign w_aempty_sat = (i_aempty_thr > L_DEPTH) ? L_DEPTH : i_aempty_thr;
    assign w_afull_eff  = i_thr_load ? w_afull_sat  : r_afull_thr;
    assign w_aempty_eff = i_thr_load ? w_aempty_sat : r_aempty_thr;

    tx_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_push_acc),
        .i_waddr (r_wptr[PTR_W-2:0]),
        .i_wdata (i_wdata),
        .i_raddr (r_rptr[PTR_W-2:0]),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_level      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_afull      <= 1'b0;
            r_aempty     <= 1'b1;
            r_afull_thr  <= L_RST_AFULL;
            r_aempty_thr <= L_RST_AEMPTY;
        end else begin
            if (w_push_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (i_thr_load) begin
                r_afull_thr  <= w_afull_sat;
                r_aempty_thr <= w_aempty_sat;
            end
            r_level  <= w_level_next;
            r_full   <= (w_level_next == L_DEPTH);
            r_empty  <= (w_level_next == '0);
            r_afull  <= (w_level_next >= w_afull_eff);
            r_aempty <= (w_level_next <= w_aempty_eff);
        end
    end

    // Set beats clear when an error and i_clr_err land on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (i_push & ~w_push_acc) | (r_overflow  & ~i_clr_err);
            r_underflow <= (i_pop  &  w_ptr_empty) | (r_underflow & ~i_clr_err);
        end
    end

`ifdef TX_SYNC_FIFO_FWFT_EN
    assign o_rdata  = r_empty ? '0 : w_ram_rdata;
    assign o_rvalid = ~r_empty;
`else
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_pop_acc;
            if (w_pop_acc) begin
                r_rdata <= w_ram_rdata;
            end
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;
`endif

    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_level        = r_level;
    assign o_almost_full  = r_afull;
    assign o_almost_empty = r_aempty;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_tx_sync_fifo.sv
// tb/tb_tx_sync_fifo.sv - self-checking bench for tx_sync_fifo (default registered-read build)
module tb_tx_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       i_push;
    logic [7:0] i_wdata;
    logic       i_pop;
    logic [7:0] o_rdata;
    logic       o_rvalid;
    logic       o_full;
    logic       o_empty;
    logic [4:0] o_level;
    logic       i_thr_load;
    logic [4:0] i_afull_thr;
    logic [4:0] i_aempty_thr;
    logic       o_almost_full;
    logic       o_almost_empty;
    logic       o_overflow;
    logic       o_underflow;
    logic       i_clr_err;

    int n_cmp = 0;
    int n_err = 0;

    tx_sync_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_push         (i_push),
        .i_wdata        (i_wdata),
        .i_pop          (i_pop),
        .o_rdata        (o_rdata),
        .o_rvalid       (o_rvalid),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_level        (o_level),
        .i_thr_load     (i_thr_load),
        .i_afull_thr    (i_afull_thr),
        .i_aempty_thr   (i_aempty_thr),
        .o_almost_full  (o_almost_full),
        .o_almost_empty (o_almost_empty),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow),
        .i_clr_err      (i_clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of words plus the flag rules.
    logic [7:0] mq[$];
    logic [7:0] m_rdata;
    bit         m_rvalid;
    bit         m_ovf;
    bit         m_udf;
    int         m_athr;
    int         m_ethr;

    always @(posedge clk or negedge rst_n) begin
        int  n;
        bit  pa;
        bit  pu;
        if (!rst_n) begin
            mq.delete();
            m_rdata  = 8'h00;
            m_rvalid = 1'b0;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
            m_athr   = 14;
            m_ethr   = 2;
        end else begin
            n  = mq.size();
            pa = i_pop && (n > 0);
            pu = i_push && ((n < 16) || pa);
            m_rvalid = pa;
            if (pa) m_rdata = mq.pop_front();
            if (pu) mq.push_back(i_wdata);
            if (i_thr_load) begin
                m_athr = (int'(i_afull_thr)  > 16) ? 16 : int'(i_afull_thr);
                m_ethr = (int'(i_aempty_thr) > 16) ? 16 : int'(i_aempty_thr);
            end
            m_ovf = (i_push && !pu)    || (m_ovf && !i_clr_err);
            m_udf = (i_pop && (n == 0)) || (m_udf && !i_clr_err);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("rdata",  32'(o_rdata),        32'(m_rdata));
        chk("rvalid", 32'(o_rvalid),       32'(m_rvalid));
        chk("level",  32'(o_level),        32'(mq.size()));
        chk("full",   32'(o_full),         32'(mq.size() == 16));
        chk("empty",  32'(o_empty),        32'(mq.size() == 0));
        chk("afull",  32'(o_almost_full),  32'(mq.size() >= m_athr));
        chk("aempty", 32'(o_almost_empty), 32'(mq.size() <= m_ethr));
        chk("ovf",    32'(o_overflow),     32'(m_ovf));
        chk("udf",    32'(o_underflow),    32'(m_udf));
    end

    task automatic drive(input bit p, input logic [7:0] d, input bit po, input bit clr = 1'b0);
        i_push    = p;
        i_wdata   = d;
        i_pop     = po;
        i_clr_err = clr;
        @(posedge clk);
        #1;
        i_push     = 1'b0;
        i_pop      = 1'b0;
        i_clr_err  = 1'b0;
        i_thr_load = 1'b0;
    endtask

    initial begin
        int  phase_push;
        int  phase_pop;
        rst_n        = 1'b0;
        i_push       = 1'b0;
        i_wdata      = 8'h00;
        i_pop        = 1'b0;
        i_thr_load   = 1'b0;
        i_afull_thr  = 5'd0;
        i_aempty_thr = 5'd0;
        i_clr_err    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level",  32'(o_level), 32'd0);
        chk("rst_empty",  32'(o_empty), 32'd1);
        chk("rst_aempty", 32'(o_almost_empty), 32'd1);
        chk("rst_rvalid", 32'(o_rvalid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0);
        chk("fill_full",  32'(o_full),  32'd1);
        chk("fill_level", 32'(o_level), 32'd16);

        drive(1'b1, 8'hAA, 1'b0);
        chk("ovf_set",   32'(o_overflow), 32'd1);
        chk("ovf_level", 32'(o_level),    32'd16);

        drive(1'b1, 8'h77, 1'b1);
        chk("fpp_data",  32'(o_rdata),  32'h00);
        chk("fpp_valid", 32'(o_rvalid), 32'd1);
        chk("fpp_level", 32'(o_level),  32'd16);

        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            chk("drain_data", 32'(o_rdata), 32'(i));
        end
        drive(1'b0, 8'h00, 1'b1);
        chk("drain_last", 32'(o_rdata), 32'h77);
        chk("drain_empty", 32'(o_empty), 32'd1);
        drive(1'b0, 8'h00, 1'b0);
        chk("rvalid_drop", 32'(o_rvalid), 32'd0);
        chk("rdata_hold",  32'(o_rdata),  32'h77);

        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(o_overflow), 32'd0);

        drive(1'b1, 8'h55, 1'b1);
        chk("udf_set",    32'(o_underflow), 32'd1);
        chk("udf_rvalid", 32'(o_rvalid),    32'd0);
        chk("udf_level",  32'(o_level),     32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        chk("udf_data", 32'(o_rdata),     32'h55);
        chk("udf_clr",  32'(o_underflow), 32'd0);

        i_thr_load   = 1'b1;
        i_afull_thr  = 5'd12;
        i_aempty_thr = 5'd3;
        drive(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0);
            if (i == 10) chk("afull_11", 32'(o_almost_full), 32'd0);
        end
        chk("afull_12", 32'(o_almost_full), 32'd1);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            if (i == 7) chk("aempty_4", 32'(o_almost_empty), 32'd0);
        end
        chk("aempty_3", 32'(o_almost_empty), 32'd1);

        i_thr_load   = 1'b1;
        i_afull_thr  = 5'd31;
        i_aempty_thr = 5'd20;
        drive(1'b0, 8'h00, 1'b0);
        chk("sat_aempty", 32'(o_almost_empty), 32'd1);

        phase_push = 50;
        phase_pop  = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                phase_push = $urandom_range(10, 90);
                phase_pop  = 100 - phase_push;
            end
            if (c == 1500) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 99) < 2) begin
                i_thr_load   = 1'b1;
                i_afull_thr  = 5'($urandom_range(0, 31));
                i_aempty_thr = 5'($urandom_range(0, 31));
            end
            drive($urandom_range(0, 99) < phase_push, 8'($urandom),
                  $urandom_range(0, 99) < phase_pop, $urandom_range(0, 99) < 3);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
